seg7_scanner: RTL and testbench
===============================

# seg7_scanner

Time-multiplexed driver for a 4-digit common-anode seven-segment display. It sits directly downstream of the memory-mapped peripheral block and consumes its display register: a 16-bit hex value, decimal-point mask, brightness and control bits. From these it generates the registered anode and segment pins. It provides per-frame value shadowing (no tearing), leading-zero blanking and 16-level PWM brightness.

## Interface
- SUB_DIV, 1563: clk cycles per PWM step; 16 steps form one digit slot, and 4 slots form one frame.
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high
- enable  in  1  display on; 0 forces all outputs dark
- value  in  16  hex digits; digit i = value[4i+3:4i], digit 0 is rightmost
- dp_mask  in  4  decimal point per digit; 1 = lit
- blank_lz  in  1  suppress leading zeros
- brightness  in  4  duty in sixteenths; 0 = dark, 15 = 15/16
- an  out  4  anode enables, active-low; an[i] selects digit i
- seg  out  8  {dp,g,f,e,d,c,b,a}, active-low
- frame_start  out  1  one-cycle pulse on each shadow load

## Operation
- Counters:
  - sub_cnt counts 0..SUB_DIV-1.
  - At wrap, pwm_ph (0..15) increments.
  - When pwm_ph wraps 15->0, dig (0..3) increments.
  - When dig wraps 3->0, a frame boundary occurs.
- Shadow registers sh_value, sh_dp, sh_lz and sh_bright load from the inputs on every frame boundary. They also load on the first cycle after enable rises, when all counters restart at 0. frame_start pulses on each load. Mid-frame input changes have no visible effect until the next load.
- Digit on condition: enable=1, pwm_ph < sh_bright, and the digit is not blanked.
- Leading-zero blanking: with sh_lz=1, digit i (i=3..1) is blanked iff its nibble and all higher nibbles are 0. Digit 0 is never blanked.
- A blanked digit shows only its dp: if sh_dp[i]=1, an[i]=0 and seg=8'h7F. Otherwise an is all off.
- Decode (a..g lit, active-high before inversion):
  - 0:3F, 1:06, 2:5B, 3:4F, 4:66, 5:6D, 6:7D, 7:07
  - 8:7F, 9:6F, A:77, b:7C, C:39, d:5E, E:79, F:71
  - dp bit = sh_dp[dig]
- When the digit is on: an = ~(4'b1 << dig), seg = ~{dp, decode}.
- When the digit is off: an = 4'hF, seg = 8'hFF.
- When enable=0, outputs are forced dark and all counters are held at 0.
- Reset values: an=4'hF, seg=8'hFF, frame_start=0, all counters 0, all shadows 0.
- Reset mid-frame returns the block to the dark state immediately (asynchronous). After release, the first frame begins with a shadow load on the first clock where enable=1.

## Timing
- Outputs are registered. They reflect the counter/shadow state one clk after it changes.
- An input change reaches the pins no later than 1 frame + 1 cycle, where a frame is 64*SUB_DIV cycles.
- Digit switch: an and seg change in the same cycle. There is never a cycle in which a new anode is driven with old segments.
- Full brightness (15) leaves step 15 of each slot dark. This is the inter-digit ghosting guard.
- An enable fall takes effect on the next clk edge: outputs are dark 1 cycle later.
- An enable rise loads the shadows on that edge; the first lit output appears 1 cycle later.
- SUB_DIV=1 is legal: the PWM step advances every cycle.

## Structure
- Package seg7_pkg holds:
  - SEG_OFF=8'hFF and AN_OFF=4'hF
  - the 16-entry hex segment constant table
  - the dig/pwm_ph widths
- Sub-module seg7_decode: combinational nibble to 7-bit segment decode. It is instantiated once, on the selected digit.
- The counters, shadow registers, blanking logic and output registers live in seg7_scanner.

## Test plan
- Bench runs with SUB_DIV=2.
- Reset release, enable=1, value=16'h1234, brightness=15, blank_lz=0: digits scan an=E,D,B,7 in order with seg=F9(1 on an=7),B0,A4,99 for digit0=4 → seg 8'h99. Each digit is lit for 30 of its 32 cycles.
- value changes 16'h1234→16'hABCD mid-frame: the remainder of the frame still shows 1234. The next frame shows ABCD, and frame_start pulses on the switch cycle.
- blank_lz=1, value=16'h0050, dp_mask=4'b1000: digit3 shows dp only (an=7, seg=7F), digit2 is dark, digit1 shows 5, digit0 shows 0.
- brightness=0: an stays F for a full frame. brightness=4: each digit is lit for exactly 8 of its 32 cycles, on steps 0-3.
- enable 1→0 mid-slot: outputs are dark on the next cycle. Re-enable: frame_start pulses and digit 0 is lit after 1 cycle.
- Assert reset mid-frame: an=F and seg=FF immediately. After release, scanning restarts at digit 0.

Source files
------------

// File: rtl/seg7_pkg.sv
// Shared constants for the seven-segment scanner: pin idle levels,
// counter widths and the hex glyph table (a..g, active-high).
package seg7_pkg;

    localparam int DIG_W = 2;
    localparam int PWM_W = 4;

    localparam logic [7:0] SEG_OFF     = 8'hFF;
    localparam logic [3:0] AN_OFF      = 4'hF;
    localparam logic [7:0] SEG_DP_ONLY = 8'h7F;

    localparam logic [6:0] HEX_SEG [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

endpackage

// File: rtl/seg7_scanner_if.sv
// Display-register bundle from the peripheral block plus the display pins.
interface seg7_scanner_if;

    logic        enable;
    logic [15:0] value;
    logic [3:0]  dp_mask;
    logic        blank_lz;
    logic [3:0]  brightness;
    logic [3:0]  an;
    logic [7:0]  seg;
    logic        frame_start;

    modport master (
        output enable, value, dp_mask, blank_lz, brightness,
        input  an, seg, frame_start
    );

    modport slave (
        input  enable, value, dp_mask, blank_lz, brightness,
        output an, seg, frame_start
    );

endinterface

// File: rtl/seg7_decode.sv
// Combinational hex nibble to a..g segment pattern (active-high).
module seg7_decode
    import seg7_pkg::*;
(
    input  logic [3:0] nibble_i,
    output logic [6:0] seg_o
);

    // Glyph lookup
    always_comb begin
        seg_o = HEX_SEG[nibble_i];
    end

endmodule

// File: rtl/seg7_scanner_chk.sv
// Structural properties of the display pins; carries no functional logic.
module seg7_scanner_chk
    import seg7_pkg::*;
(
    input logic       clk,
    input logic       reset,
    input logic       enable_i,
    input logic [3:0] an_i,
    input logic [7:0] seg_i,
    input logic       frame_start_i
);

    a_an_legal: assert property (@(posedge clk) disable iff (reset)
        (an_i == AN_OFF) || $onehot(~an_i));

    a_dark_seg: assert property (@(posedge clk) disable iff (reset)
        (an_i == AN_OFF) |-> (seg_i == SEG_OFF));

    a_disabled_dark: assert property (@(posedge clk) disable iff (reset)
        !enable_i |=> (an_i == AN_OFF) && !frame_start_i);

endmodule

// File: rtl/seg7_scanner.sv
// Four-digit multiplexed seven-segment driver with per-frame shadowing,
// leading-zero blanking and 16-step PWM brightness.
module seg7_scanner
    import seg7_pkg::*;
#(
    parameter int SUB_DIV = 1563
)(
    input  logic          clk,
    input  logic          reset,
    seg7_scanner_if.slave bus
);

    localparam int               SUB_W    = (SUB_DIV > 1) ? $clog2(SUB_DIV) : 1;
    localparam logic [SUB_W-1:0] SUB_LAST = SUB_W'(SUB_DIV - 1);
    localparam logic [SUB_W-1:0] SUB_ONE  = SUB_W'(1);
    localparam logic [SUB_W-1:0] SUB_ZERO = {SUB_W{1'b0}};

    logic [SUB_W-1:0] sub_cnt_q, sub_cnt_d;
    logic [PWM_W-1:0] pwm_ph_q, pwm_ph_d;
    logic [DIG_W-1:0] dig_q, dig_d;
    logic             run_q, run_d;
    logic [15:0]      sh_value_q, sh_value_d;
    logic [3:0]       sh_dp_q, sh_dp_d;
    logic             sh_lz_q, sh_lz_d;
    logic [3:0]       sh_bright_q, sh_bright_d;
    logic [3:0]       an_q, an_d;
    logic [7:0]       seg_q, seg_d;
    logic             frame_start_q, frame_start_d;

    logic       sub_wrap_s, pwm_wrap_s, frame_end_s, load_s;
    logic [3:0] nibble_s;
    logic [6:0] glyph_s;
    logic       blank3_s, blank2_s, blank1_s;
    logic [3:0] blank_s;
    logic       slot_on_s;
    logic [3:0] an_sel_s;

    // Counter wrap detection and shadow-load strobe
    always_comb begin
        sub_wrap_s  = (sub_cnt_q == SUB_LAST);
        pwm_wrap_s  = sub_wrap_s && (pwm_ph_q == {PWM_W{1'b1}});
        frame_end_s = pwm_wrap_s && (dig_q == {DIG_W{1'b1}});
        // run_q low means the first enabled edge: restart and resample inputs
        load_s      = bus.enable && (!run_q || frame_end_s);
    end

    // Scan counter next state; held at zero while disabled or restarting
    always_comb begin
        sub_cnt_d = sub_cnt_q;
        pwm_ph_d  = pwm_ph_q;
        dig_d     = dig_q;
        run_d     = bus.enable;
        if (!bus.enable || !run_q) begin
            sub_cnt_d = SUB_ZERO;
            pwm_ph_d  = {PWM_W{1'b0}};
            dig_d     = {DIG_W{1'b0}};
        end else if (sub_wrap_s) begin
            sub_cnt_d = SUB_ZERO;
            pwm_ph_d  = pwm_ph_q + PWM_W'(1);
            if (pwm_wrap_s) begin
                dig_d = dig_q + DIG_W'(1);
            end else begin
                dig_d = dig_q;
            end
        end else begin
            sub_cnt_d = sub_cnt_q + SUB_ONE;
        end
    end

    // Shadow registers capture the display register once per frame
    always_comb begin
        sh_value_d  = sh_value_q;
        sh_dp_d     = sh_dp_q;
        sh_lz_d     = sh_lz_q;
        sh_bright_d = sh_bright_q;
        if (load_s) begin
            sh_value_d  = bus.value;
            sh_dp_d     = bus.dp_mask;
            sh_lz_d     = bus.blank_lz;
            sh_bright_d = bus.brightness;
        end else begin
            sh_value_d  = sh_value_q;
            sh_dp_d     = sh_dp_q;
            sh_lz_d     = sh_lz_q;
            sh_bright_d = sh_bright_q;
        end
    end

    // Nibble of the digit currently being scanned
    always_comb begin
        case (dig_q)
            2'd0:    nibble_s = sh_value_q[3:0];
            2'd1:    nibble_s = sh_value_q[7:4];
            2'd2:    nibble_s = sh_value_q[11:8];
            2'd3:    nibble_s = sh_value_q[15:12];
            default: nibble_s = 4'h0;
        endcase
    end

    seg7_decode u_decode (
        .nibble_i (nibble_s),
        .seg_o    (glyph_s)
    );

    // Leading-zero blanking cascades down from the most significant digit
    always_comb begin
        blank3_s = sh_lz_q && (sh_value_q[15:12] == 4'h0);
        blank2_s = blank3_s && (sh_value_q[11:8] == 4'h0);
        blank1_s = blank2_s && (sh_value_q[7:4] == 4'h0);
        blank_s  = {blank3_s, blank2_s, blank1_s, 1'b0};
    end

    // Pin values for the next cycle; anode and segments always move together
    always_comb begin
        slot_on_s     = bus.enable && run_q && (pwm_ph_q < sh_bright_q);
        an_sel_s      = ~(4'b0001 << dig_q);
        an_d          = AN_OFF;
        seg_d         = SEG_OFF;
        frame_start_d = load_s;
        if (slot_on_s && !blank_s[dig_q]) begin
            an_d  = an_sel_s;
            seg_d = ~{sh_dp_q[dig_q], glyph_s};
        end else if (slot_on_s && sh_dp_q[dig_q]) begin
            an_d  = an_sel_s;
            seg_d = SEG_DP_ONLY;
        end else begin
            an_d  = AN_OFF;
            seg_d = SEG_OFF;
        end
    end

    // State, shadow and output registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sub_cnt_q     <= SUB_ZERO;
            pwm_ph_q      <= {PWM_W{1'b0}};
            dig_q         <= {DIG_W{1'b0}};
            run_q         <= 1'b0;
            sh_value_q    <= 16'h0000;
            sh_dp_q       <= 4'h0;
            sh_lz_q       <= 1'b0;
            sh_bright_q   <= 4'h0;
            an_q          <= AN_OFF;
            seg_q         <= SEG_OFF;
            frame_start_q <= 1'b0;
        end else begin
            sub_cnt_q     <= sub_cnt_d;
            pwm_ph_q      <= pwm_ph_d;
            dig_q         <= dig_d;
            run_q         <= run_d;
            sh_value_q    <= sh_value_d;
            sh_dp_q       <= sh_dp_d;
            sh_lz_q       <= sh_lz_d;
            sh_bright_q   <= sh_bright_d;
            an_q          <= an_d;
            seg_q         <= seg_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign bus.an          = an_q;
    assign bus.seg         = seg_q;
    assign bus.frame_start = frame_start_q;

    seg7_scanner_chk u_chk (
        .clk           (clk),
        .reset         (reset),
        .enable_i      (bus.enable),
        .an_i          (an_q),
        .seg_i         (seg_q),
        .frame_start_i (frame_start_q)
    );

endmodule

// File: tb/tb_seg7_scanner.sv
// Randomized bench for seg7_scanner against a frame-position reference model.
module tb_seg7_scanner;

    localparam int SD    = 2;
    localparam int SLOT  = 16 * SD;
    localparam int FRAME = 64 * SD;

    logic clk;
    logic reset;

    seg7_scanner_if bus ();

    seg7_scanner #(.SUB_DIV(SD)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [6:0] seg_tab [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    int n_checks = 0;
    int n_fail   = 0;
    int lit_cnt [4];

    // reference model: running flag, position within the frame, captured inputs
    bit          m_run;
    int          m_pos;
    logic [15:0] m_value;
    logic [3:0]  m_dp;
    logic        m_lz;
    logic [3:0]  m_bright;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic void model_reset();
        m_run    = 1'b0;
        m_pos    = 0;
        m_value  = 16'h0000;
        m_dp     = 4'h0;
        m_lz     = 1'b0;
        m_bright = 4'h0;
    endfunction

    function automatic void exp_pins(input int p, output logic [3:0] a, output logic [7:0] s);
        int         d;
        int         ph;
        logic [3:0] nib;
        logic [3:0] sel;
        bit         blanked;
        d       = p / SLOT;
        ph      = (p / SD) % 16;
        nib     = m_value[4*d +: 4];
        blanked = m_lz && (d > 0) && ((m_value >> (4*d)) == 16'h0000);
        sel     = 4'b0001 << d;
        a       = 4'hF;
        s       = 8'hFF;
        if (ph < int'(m_bright)) begin
            if (!blanked) begin
                a = ~sel;
                s = ~{m_dp[d], seg_tab[nib]};
            end else if (m_dp[d]) begin
                a = ~sel;
                s = 8'h7F;
            end
        end
    endfunction

    task automatic step();
        logic [3:0] ea;
        logic [7:0] es;
        logic       ef;
        logic [3:0] sel;
        @(posedge clk);
        ea = 4'hF;
        es = 8'hFF;
        ef = 1'b0;
        if (reset) begin
            model_reset();
        end else begin
            if (bus.enable && m_run) exp_pins(m_pos, ea, es);
            ef = bus.enable && (!m_run || m_pos == FRAME - 1);
            if (!bus.enable) begin
                m_run = 1'b0;
                m_pos = 0;
            end else if (!m_run || m_pos == FRAME - 1) begin
                m_run    = 1'b1;
                m_pos    = 0;
                m_value  = bus.value;
                m_dp     = bus.dp_mask;
                m_lz     = bus.blank_lz;
                m_bright = bus.brightness;
            end else begin
                m_pos++;
            end
        end
        #1;
        check_eq("an", bus.an, ea);
        check_eq("seg", bus.seg, es);
        check_eq("frame_start", bus.frame_start, ef);
        for (int i = 0; i < 4; i++) begin
            sel = 4'b0001 << i;
            if (bus.an == ~sel) lit_cnt[i]++;
        end
    endtask

    task automatic restart();
        bus.enable = 1'b0;
        step();
        bus.enable = 1'b1;
        step();
    endtask

    task automatic count_frame(input int e3, input int e2, input int e1, input int e0);
        for (int i = 0; i < 4; i++) lit_cnt[i] = 0;
        repeat (FRAME) step();
        check_eq("lit_d3", lit_cnt[3], e3);
        check_eq("lit_d2", lit_cnt[2], e2);
        check_eq("lit_d1", lit_cnt[1], e1);
        check_eq("lit_d0", lit_cnt[0], e0);
    endtask

    task automatic do_reset();
        #3;
        reset = 1'b1;
        #1;
        check_eq("rst_an", bus.an, 4'hF);
        check_eq("rst_seg", bus.seg, 8'hFF);
        check_eq("rst_fs", bus.frame_start, 1'b0);
        model_reset();
        step();
        step();
        reset = 1'b0;
    endtask

    initial begin
        logic [15:0] v;
        reset          = 1'b1;
        bus.enable     = 1'b0;
        bus.value      = 16'h0000;
        bus.dp_mask    = 4'h0;
        bus.blank_lz   = 1'b0;
        bus.brightness = 4'h0;
        model_reset();
        repeat (3) step();
        reset = 1'b0;
        repeat (2) step();

        // 1234 at full brightness, aligned to the first frame after enable
        bus.value      = 16'h1234;
        bus.brightness = 4'd15;
        bus.enable     = 1'b1;
        step();
        count_frame(30, 30, 30, 30);

        // mid-frame value change must wait for the next frame
        repeat (50) step();
        bus.value = 16'hABCD;
        repeat (200) step();

        // leading-zero blanking with a dp on a blanked digit
        bus.value    = 16'h0050;
        bus.dp_mask  = 4'b1000;
        bus.blank_lz = 1'b1;
        restart();
        count_frame(30, 0, 30, 30);

        bus.brightness = 4'd0;
        restart();
        count_frame(0, 0, 0, 0);

        bus.brightness = 4'd4;
        bus.blank_lz   = 1'b0;
        bus.dp_mask    = 4'h0;
        bus.value      = 16'h1234;
        restart();
        count_frame(8, 8, 8, 8);

        // enable drop in the middle of a slot, then re-enable
        bus.brightness = 4'd15;
        repeat (37) step();
        bus.enable = 1'b0;
        repeat (3) step();
        bus.enable = 1'b1;
        repeat (20) step();

        // asynchronous reset mid-frame
        repeat (50) step();
        do_reset();
        repeat (140) step();

        for (int it = 0; it < 40; it++) begin
            v = 16'($urandom);
            v = v >> (4 * $urandom_range(0, 3));
            bus.value      = v;
            bus.dp_mask    = 4'($urandom);
            bus.blank_lz   = 1'($urandom);
            bus.brightness = 4'($urandom);
            if ($urandom_range(0, 3) == 0) bus.enable = ~bus.enable;
            if ($urandom_range(0, 9) == 0) do_reset();
            repeat ($urandom_range(1, 200)) step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
